pwm_spi_regfile: RTL and testbench

SPI-slave register file that configures the PWM peripheral of the onboarding design. It synchronises an external SPI mode-0 bus into the `clk` domain, decodes 16-bit write/read frames, and holds the five 8-bit control registers that drive the PWM peripheral's output-enable, PWM-enable and duty-cycle inputs. It sits between the top-level pins (SPI on `ui_in`/`uo_out` bits) and the PWM peripheral instance.

---
 rtl/pwm_spi_regfile.sv | 159 +++++++++++++++
 tb/tb_pwm_spi_regfile.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_spi_regfile.sv
// SPI mode-0 slave register file feeding the PWM peripheral controls.
// SPI pins are synchronised into clk; 16-bit frames write or read five 8-bit registers.
module pwm_spi_regfile #(
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_pulse
);

  localparam int unsigned REG_SLOTS = (NUM_REGS > 5) ? NUM_REGS : 5;

  localparam logic [1:0] S_WAIT_IDLE = 2'd0;
  localparam logic [1:0] S_IDLE      = 2'd1;
  localparam logic [1:0] S_SHIFT     = 2'd2;
  localparam logic [1:0] S_OVERRUN   = 2'd3;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_copi_sync;
  logic [SYNC_STAGES-1:0] r_ncs_sync;
  logic                   r_sclk_hist;
  logic                   r_ncs_hist;

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [15:0] r_shift;
  logic [7:0]  r_out_sh;
  logic [3:0]  r_rd_cnt;
  logic [7:0]  r_regs [REG_SLOTS];

  logic        w_sclk;
  logic        w_copi;
  logic        w_ncs;
  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic        w_ncs_rise;
  logic        w_ncs_fall;
  logic [15:0] w_sh_next;
  logic [4:0]  w_cnt_next;
  logic        w_wr_hit;
  logic [7:0]  w_rd_data;

  // ncs chain resets low so a frame already in progress at reset release is never seen as a start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
      r_ncs_sync  <= '0;
      r_sclk_hist <= 1'b0;
      r_ncs_hist  <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
      r_sclk_hist <= w_sclk;
      r_ncs_hist  <= w_ncs;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_copi      = r_copi_sync[SYNC_STAGES-1];
  assign w_ncs       = r_ncs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_hist;
  assign w_sclk_fall = ~w_sclk & r_sclk_hist;
  assign w_ncs_rise  = w_ncs & ~r_ncs_hist;
  assign w_ncs_fall  = ~w_ncs & r_ncs_hist;

  assign w_sh_next  = {r_shift[14:0], w_copi};
  assign w_cnt_next = r_cnt + 5'd1;
  assign w_wr_hit   = (r_cnt == 5'd16) && r_shift[15] && (32'(r_shift[14:8]) < NUM_REGS);

  // Read source uses the address as it will stand after the 8th bit lands
  always_comb begin
    w_rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (w_sh_next[6:0] == 7'(i)) w_rd_data = r_regs[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_WAIT_IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_out_sh <= '0;
      r_rd_cnt <= '0;
      cipo     <= 1'b0;
      wr_pulse <= 1'b0;
      for (int unsigned i = 0; i < REG_SLOTS; i++) r_regs[i] <= '0;
    end else begin
      wr_pulse <= 1'b0;
      if (r_state == S_WAIT_IDLE) begin
        if (w_ncs) r_state <= S_IDLE;
      end else if (w_ncs_rise) begin
        // End of frame takes priority over any sclk edge seen in the same cycle
        r_state  <= S_IDLE;
        r_rd_cnt <= '0;
        cipo     <= 1'b0;
        if (w_wr_hit) begin
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (r_shift[14:8] == 7'(i)) r_regs[i] <= r_shift[7:0];
          end
          wr_pulse <= 1'b1;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_ncs_fall) begin
              r_state  <= S_SHIFT;
              r_cnt    <= '0;
              r_shift  <= '0;
              r_rd_cnt <= '0;
            end
          end
          S_SHIFT: begin
            if (w_sclk_rise) begin
              r_shift <= w_sh_next;
              r_cnt   <= w_cnt_next;
              if (w_cnt_next == 5'd17) begin
                r_state  <= S_OVERRUN;
                r_rd_cnt <= '0;
                cipo     <= 1'b0;
              end else if (w_cnt_next == 5'd8 && !w_sh_next[7]) begin
                r_out_sh <= w_rd_data;
                r_rd_cnt <= 4'd8;
              end
            end else if (w_sclk_fall) begin
              if (r_rd_cnt != 4'd0) begin
                cipo     <= r_out_sh[7];
                r_out_sh <= {r_out_sh[6:0], 1'b0};
                r_rd_cnt <= r_rd_cnt - 4'd1;
              end else begin
                cipo <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign en_reg_out_7_0  = r_regs[0];
  assign en_reg_out_15_8 = r_regs[1];
  assign en_reg_pwm_7_0  = r_regs[2];
  assign en_reg_pwm_15_8 = r_regs[3];
  assign pwm_duty_cycle  = r_regs[4];

endmodule

// File: tb/tb_pwm_spi_regfile.sv
// Bench for pwm_spi_regfile: directed frame table, reset/back-to-back sequences,
// then random frames checked against a register-array model.
module tb_pwm_spi_regfile;

  localparam int H   = 50;   // sclk half period (clk period is 10)
  localparam int GAP = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic       cipo;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_pulse;

  pwm_spi_regfile #(.NUM_REGS(5), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  logic [7:0] model [5];

  always @(negedge clk) if (wr_pulse === 1'b1) pulse_cnt++;

  typedef struct {
    logic [15:0] frame;
    int          nbits;
    logic [39:0] exp_regs;   // {reg4, reg3, reg2, reg1, reg0}
    int          exp_pulses;
    bit          chk_rd;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] dut_regs();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  function automatic logic [39:0] model_regs();
    return {model[4], model[3], model[2], model[1], model[0]};
  endfunction

  // One SPI bit: drive copi, wait half a period, sample cipo, pulse sclk
  task automatic spi_bit(input logic b, output logic sampled);
    copi = b;
    #H;
    sampled = cipo;
    sclk = 1'b1;
    #H;
    sclk = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] f, input int nbits, input int gap,
                           output logic [7:0] rd, output int pulses);
    logic s;
    int p0;
    p0 = pulse_cnt;
    rd = '0;
    ncs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      spi_bit((i < 16) ? f[15-i] : 1'b0, s);
      if (i >= 8 && i < 16) rd[15-i] = s;
    end
    #H;
    ncs = 1'b1;
    copi = 1'b0;
    #gap;
    pulses = pulse_cnt - p0;
  endtask

  // Reference: a write commits only for an exact 16-bit frame to an implemented address
  task automatic model_frame(input logic [15:0] f, input int nbits,
                             output int exp_pulses, output logic [7:0] exp_rd);
    int addr;
    addr = int'(f[14:8]);
    exp_rd = (addr < 5) ? model[addr] : 8'h00;
    exp_pulses = 0;
    if (nbits == 16 && f[15] && addr < 5) begin
      model[addr] = f[7:0];
      exp_pulses = 1;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rd, erd;
    logic [15:0] f;
    int          pulses, epulses, nb;
    logic        s;

    vecs[0] = '{16'h80F0, 16, 40'h00_00_00_00_F0, 1, 1'b0, 8'h00};
    vecs[1] = '{16'h8480, 16, 40'h80_00_00_00_F0, 1, 1'b0, 8'h00};
    vecs[2] = '{16'h0400, 16, 40'h80_00_00_00_F0, 0, 1'b1, 8'h80};
    vecs[3] = '{16'h0000, 16, 40'h80_00_00_00_F0, 0, 1'b1, 8'hF0};
    vecs[4] = '{16'h85FF, 16, 40'h80_00_00_00_F0, 0, 1'b0, 8'h00};
    vecs[5] = '{16'hFFFF, 16, 40'h80_00_00_00_F0, 0, 1'b0, 8'h00};
    vecs[6] = '{16'h82AA, 15, 40'h80_00_00_00_F0, 0, 1'b0, 8'h00};
    vecs[7] = '{16'h82AA, 17, 40'h80_00_00_00_F0, 0, 1'b0, 8'h00};
    vecs[8] = '{16'h0500, 16, 40'h80_00_00_00_F0, 0, 1'b1, 8'h00};
    vecs[9] = '{16'h0200, 16, 40'h80_00_00_00_F0, 0, 1'b1, 8'h00};

    for (int i = 0; i < 5; i++) model[i] = 8'h00;

    rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    #23;
    chk("reset_regs", 64'(dut_regs()), 64'h0);
    chk("reset_wr_pulse", 64'(wr_pulse), 64'h0);
    chk("reset_cipo", 64'(cipo), 64'h0);
    @(negedge clk) rst = 1'b0;
    #100;

    for (int v = 0; v < 10; v++) begin
      model_frame(vecs[v].frame, vecs[v].nbits, epulses, erd);
      run_frame(vecs[v].frame, vecs[v].nbits, GAP, rd, pulses);
      chk($sformatf("vec%0d_regs", v), 64'(dut_regs()), 64'(vecs[v].exp_regs));
      chk($sformatf("vec%0d_pulses", v), 64'(pulses), 64'(vecs[v].exp_pulses));
      chk($sformatf("vec%0d_cipo_idle", v), 64'(cipo), 64'h0);
      if (vecs[v].chk_rd) chk($sformatf("vec%0d_read", v), 64'(rd), 64'(vecs[v].exp_rd));
    end

    // Back-to-back writes with minimum ncs high time
    begin
      int p0, p1, p2;
      p0 = pulse_cnt;
      run_frame(16'h8201, 16, 40, rd, p1);
      run_frame(16'h8302, 16, GAP, rd, p2);
      model[2] = 8'h01;
      model[3] = 8'h02;
      chk("b2b_regs", 64'(dut_regs()), 64'h80_02_01_00_F0);
      chk("b2b_pulses", 64'(pulse_cnt - p0), 64'd2);
    end

    // Reset in the middle of a write frame, released with ncs still low
    begin
      int p0;
      f = 16'h81FF;
      p0 = pulse_cnt;
      ncs = 1'b0;
      for (int i = 0; i < 10; i++) spi_bit(f[15-i], s);
      rst = 1'b1;
      #1;
      chk("midrst_regs_clear", 64'(dut_regs()), 64'h0);
      #29;
      @(negedge clk) rst = 1'b0;
      for (int i = 10; i < 16; i++) spi_bit(f[15-i], s);
      #H;
      ncs = 1'b1;
      #GAP;
      for (int i = 0; i < 5; i++) model[i] = 8'h00;
      chk("midrst_regs_after", 64'(dut_regs()), 64'h0);
      chk("midrst_pulses", 64'(pulse_cnt - p0), 64'd0);
      model_frame(16'h81FF, 16, epulses, erd);
      run_frame(16'h81FF, 16, GAP, rd, pulses);
      chk("postrst_regs", 64'(dut_regs()), 64'h00_00_00_FF_00);
      chk("postrst_pulses", 64'(pulses), 64'd1);
    end

    // Random frames against the model
    for (int k = 0; k < 40; k++) begin
      f = 16'($urandom);
      if ($urandom_range(0, 3) != 0) f[14:8] = 7'($urandom_range(0, 6));
      case ($urandom_range(0, 5))
        0: nb = 15;
        1: nb = 17;
        default: nb = 16;
      endcase
      model_frame(f, nb, epulses, erd);
      run_frame(f, nb, GAP, rd, pulses);
      chk($sformatf("rnd%0d_regs f=%h n=%0d", k, f, nb), 64'(dut_regs()), 64'(model_regs()));
      chk($sformatf("rnd%0d_pulses", k), 64'(pulses), 64'(epulses));
      if (nb == 16 && !f[15]) chk($sformatf("rnd%0d_read", k), 64'(rd), 64'(erd));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
